muldiv_sequencer: RTL

Iterative multiply/divide sequencer for the RV32M instructions. It sits beside the main ALU in the EX stage and runs one shift-add or restoring-divide step per cycle. It stalls the pipeline while an operation is in flight and presents the 32-bit result with a one-cycle done pulse. The decode stage steers M-extension instructions (funct7 = 0000001, op = 0110011) here instead of to the ALU.

---
 rtl/muldiv_sequencer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring-divide
// step per cycle, fixed XLEN+1 cycle latency, one-cycle done pulse.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, FINISH} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   acc_hi;
    logic [XLEN-1:0]   acc_lo;
    logic              neg;
    logic              spec;
    logic [XLEN-1:0]   spec_val;

    logic              accept;
    logic              load;
    logic              step;
    logic              finish;

    // Operand preparation at accept: magnitudes, result sign, special cases
    logic              signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_in, div_zero, div_ovf;
    logic [XLEN-1:0]   spec_in;

    always_comb begin
        signed_a = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
        signed_b = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        sign_a   = signed_a && src_a[XLEN-1];
        sign_b   = signed_b && src_b[XLEN-1];
        mag_a    = sign_a ? XLEN'(XLEN'(0) - src_a) : src_a;
        mag_b    = sign_b ? XLEN'(XLEN'(0) - src_b) : src_b;
        neg_in   = (funct3[2] && funct3[1]) ? sign_a : (sign_a ^ sign_b);
        div_zero = funct3[2] && (src_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (src_a == MIN_NEG) && (src_b == '1);
        if (div_zero) begin
            spec_in = funct3[1] ? src_a : '1;
        end else begin
            spec_in = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One iteration of shift-add (MUL) or restoring division (DIV)
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              q_bit;
    logic [XLEN-1:0]   step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        q_bit     = !div_diff[XLEN];
        if (state == DIV_RUN) begin
            step_hi = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], q_bit};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    // Sign correction and field select on the value produced by the last step
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   hi_fix, lo_fix, fin;

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg ? (2*XLEN)'((2*XLEN)'(0) - prod) : prod;
        hi_fix   = neg ? XLEN'(XLEN'(0) - step_hi) : step_hi;
        lo_fix   = neg ? XLEN'(XLEN'(0) - step_lo) : step_lo;
        if (spec) begin
            fin = spec_val;
        end else if (op == 3'b000) begin
            fin = prod_fix[XLEN-1:0];
        end else if (!op[2]) begin
            fin = prod_fix[2*XLEN-1:XLEN];
        end else if (op[1]) begin
            fin = hi_fix;
        end else begin
            fin = lo_fix;
        end
    end

    assign accept = (state == IDLE) && start && !flush;
    assign busy   = (state == MUL_RUN) || (state == DIV_RUN);
    assign stall  = accept || busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load       = 1'b1;
                        state_next = funct3[2] ? DIV_RUN : MUL_RUN;
                    end
                end
                MUL_RUN, DIV_RUN: begin
                    step = 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        finish     = 1'b1;
                        state_next = FINISH;
                    end
                end
                FINISH: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath registers; the multiplier/dividend shares acc_lo
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op       <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            neg      <= 1'b0;
            spec     <= 1'b0;
            spec_val <= '0;
        end else if (load) begin
            cnt      <= CNT_W'(XLEN);
            op       <= funct3;
            opnd     <= funct3[2] ? mag_b : mag_a;
            acc_hi   <= '0;
            acc_lo   <= funct3[2] ? mag_a : mag_b;
            neg      <= neg_in;
            spec     <= div_zero || div_ovf;
            spec_val <= spec_in;
        end else if (step) begin
            cnt      <= cnt - CNT_W'(1);
            acc_hi   <= step_hi;
            acc_lo   <= step_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= finish;
            if (finish) begin
                result <= fin;
            end
        end
    end

endmodule
